alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Clear  in  1  synchronous active-high reset.
REQ-003 Start  in  1  request to execute one instruction; sampled only in IDLE.
REQ-004 IR  in  32  datapath IR contents: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes, same meaning as the DataPath ports.
REQ-006 Rout  out  16  one-hot register-output select; bit n drives RnOut.
REQ-007 Rin  out  16  one-hot register-load select; bit n drives Rnin.
REQ-008 AluOp  out  13  one-hot ALU select, bit order {ADD,SUB,SHR,SHRA,SHL,ROR,ROL,AND,OR,MUL,DIV,NEG,NOT}, MSB first.
REQ-009 Busy  out  1  high in every state except IDLE.
REQ-010 Done  out  1  one-cycle pulse at completion.
REQ-011 Illegal  out  1  high with Done when opcode unsupported.

Function
REQ-012 States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE; one clock per state.
REQ-013 All outputs Moore-decoded from the registered state plus IR; unlisted outputs 0 in each state.
REQ-014 IDLE: Start=1 -> T0; else stay.
REQ-015 T0: PCout, MARin, IncPC, Zin.
REQ-016 T1: Zlowout, PCin, Read, MDRin.
REQ-017 T2: MDRout, IRin; IR input valid from T3 onward.
REQ-018 Opcodes: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011, mul 01111, div 10000, neg 10001, not 10010; all others illegal.
REQ-019 T3 binary (add..shl, mul, div): Rout[Rb], Yin; -> T4.
REQ-020 T3 unary (neg, not): Rout[Rb], AluOp[op], Zin; -> T4.
REQ-021 T3 illegal: no strobes; Illegal latched 1; -> DONE.
REQ-022 T4 binary: Rout[Rc], AluOp[op], Zin; -> T5.
REQ-023 T4 unary: Zlowout, Rin[Ra]; -> DONE.
REQ-024 T5: non-mul/div: Zlowout, Rin[Ra], -> DONE; mul/div: Zlowout, LOin, -> T6.
REQ-025 T6 (mul/div only): Zhighout, HIin; -> DONE.
REQ-026 DONE: Done=1, Illegal=latched value; -> IDLE; Illegal latch cleared on entering T0.
REQ-027 Start ignored while Busy; Start held high re-triggers from DONE->IDLE->T0 (one idle cycle minimum).
REQ-028 Latency Start-cycle to Done: binary 7, mul/div 8, unary 6, illegal 5 cycles.
REQ-029 Rout and Rin never have more than one bit set; Rout and Rin never both non-zero in one cycle.
REQ-030 Ra=Rb=Rc permitted; no special handling.

Reset
REQ-031 Clear=1 at a rising edge forces IDLE regardless of state; all outputs 0, Illegal latch 0, from the following cycle.
REQ-032 Clear overrides Start in the same cycle.
REQ-033 Clear mid-instruction aborts it; no Done pulse issued.

Structure
REQ-034 Shared package alu_seq_defs: state encoding, opcode constants, AluOp bit indices.
REQ-035 One sub-module reg_sel_decode: 4-bit field + enable -> 16-bit one-hot, instanced for Rout and Rin.

Verification
REQ-036 rol R1,R2,R3: IR=0x40918000, Start 1 cycle -> T3 Rout=0x0004 Yin; T4 Rout=0x0008 ROL Zin; T5 Zlowout Rin=0x0002; Done cycle 7.
REQ-037 mul R2,R6: IR=0x78130000 -> T5 Zlowout LOin; T6 Zhighout HIin; Rin stays 0; Done cycle 8.
REQ-038 neg R4,R7: IR=0x8A380000 -> T3 Rout=0x0080 NEG Zin; T4 Zlowout Rin=0x0010; Yin never set; Done cycle 6.
REQ-039 Illegal: IR=0xF8000000 -> no strobes in T3; Done and Illegal high cycle 5; next instruction with legal IR has Illegal=0.
REQ-040 Clear in T4 of add: next cycle IDLE, all outputs 0, no Done; Start afterwards completes normally.
REQ-041 Start held high across two instructions: Done pulses each, exactly one IDLE cycle between; Start toggled while Busy has no effect.

Source files
------------

// File: rtl/alu_seq_defs.sv
// Shared definitions for the ALU instruction sequencer: state encoding,
// opcode values, AluOp bit positions and opcode classification helpers.
package alu_seq_defs;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_DONE
  } state_t;

  // Execution shape of an instruction once IR is valid
  typedef enum logic [1:0] {
    CL_BINARY,
    CL_MULDIV,
    CL_UNARY,
    CL_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam int ALU_W = 13;

  // AluOp bit positions, ADD is the MSB
  localparam int AB_ADD  = 12;
  localparam int AB_SUB  = 11;
  localparam int AB_SHR  = 10;
  localparam int AB_SHRA = 9;
  localparam int AB_SHL  = 8;
  localparam int AB_ROR  = 7;
  localparam int AB_ROL  = 6;
  localparam int AB_AND  = 5;
  localparam int AB_OR   = 4;
  localparam int AB_MUL  = 3;
  localparam int AB_DIV  = 2;
  localparam int AB_NEG  = 1;
  localparam int AB_NOT  = 0;

  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CL_BINARY;
      OP_MUL, OP_DIV:                  cls = CL_MULDIV;
      OP_NEG, OP_NOT:                  cls = CL_UNARY;
      default:                         cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic [ALU_W-1:0] alu_sel(input logic [4:0] op);
    logic [ALU_W-1:0] sel;
    sel = '0;
    case (op)
      OP_ADD:  sel[AB_ADD]  = 1'b1;
      OP_SUB:  sel[AB_SUB]  = 1'b1;
      OP_AND:  sel[AB_AND]  = 1'b1;
      OP_OR:   sel[AB_OR]   = 1'b1;
      OP_ROR:  sel[AB_ROR]  = 1'b1;
      OP_ROL:  sel[AB_ROL]  = 1'b1;
      OP_SHR:  sel[AB_SHR]  = 1'b1;
      OP_SHRA: sel[AB_SHRA] = 1'b1;
      OP_SHL:  sel[AB_SHL]  = 1'b1;
      OP_MUL:  sel[AB_MUL]  = 1'b1;
      OP_DIV:  sel[AB_DIV]  = 1'b1;
      OP_NEG:  sel[AB_NEG]  = 1'b1;
      OP_NOT:  sel[AB_NOT]  = 1'b1;
      default: sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// 4-bit register number to 16-bit one-hot select, all zero when disabled.
module reg_sel_decode (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  // One-hot expansion gated by the enable
  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Control sequencer for one ALU instruction: fetch (T0-T2), operand/execute
// steps (T3-T6) chosen by opcode class, then a one-cycle DONE.
// Strobes are decoded from the registered state and the current IR.
module alu_seq_ctrl
  import alu_seq_defs::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Start,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [12:0] AluOp,
  output logic        Busy,
  output logic        Done,
  output logic        Illegal
);

  state_t    state_q, state_d;
  logic      illegal_q, illegal_d;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  op_class_t  cls;

  logic       rout_en, rin_en;
  logic [3:0] rout_field;

  // Only the upper IR fields steer the sequencer
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];
  assign cls       = op_class(opcode);

  // Next-state and illegal-latch logic
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d   = ST_T0;
          illegal_d = 1'b0;
        end
      end
      ST_T0: state_d = ST_T1;
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ST_T3;
      ST_T3: begin
        if (cls == CL_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d   = ST_T4;
        end
      end
      ST_T4: state_d = (cls == CL_UNARY) ? ST_DONE : ST_T5;
      ST_T5: state_d = (cls == CL_MULDIV) ? ST_T6 : ST_DONE;
      ST_T6: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and illegal latch registers; Clear wins over everything
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore strobe decode; the register fields are routed through reg_sel_decode
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    AluOp      = '0;
    Done       = 1'b0;
    Illegal    = 1'b0;
    rout_en    = 1'b0;
    rin_en     = 1'b0;
    rout_field = rb;
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (cls == CL_BINARY || cls == CL_MULDIV) begin
          rout_en = 1'b1;
          Yin     = 1'b1;
        end else if (cls == CL_UNARY) begin
          rout_en = 1'b1;
          AluOp   = alu_sel(opcode);
          Zin     = 1'b1;
        end
      end
      ST_T4: begin
        if (cls == CL_BINARY || cls == CL_MULDIV) begin
          rout_en    = 1'b1;
          rout_field = rc;
          AluOp      = alu_sel(opcode);
          Zin        = 1'b1;
        end else if (cls == CL_UNARY) begin
          Zlowout = 1'b1;
          rin_en  = 1'b1;
        end
      end
      ST_T5: begin
        Zlowout = 1'b1;
        if (cls == CL_MULDIV) LOin = 1'b1;
        else                  rin_en = 1'b1;
      end
      ST_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      ST_DONE: begin
        Done    = 1'b1;
        Illegal = illegal_q;
      end
      default: ;
    endcase
  end

  assign Busy = (state_q != ST_IDLE);

  reg_sel_decode u_rout_dec (
    .field  (rout_field),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_sel_decode u_rin_dec (
    .field  (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: cycle-by-cycle strobe checks for
// rol, mul, neg, illegal and add, mid-instruction Clear, and held Start.
module tb_alu_seq_ctrl;

  logic        Clock, Clear, Start;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
  logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [12:0] AluOp;
  logic        Busy, Done, Illegal;
  logic [13:0] strb;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [13:0] B_PCOUT  = 14'h2000;
  localparam logic [13:0] B_MARIN  = 14'h1000;
  localparam logic [13:0] B_INCPC  = 14'h0800;
  localparam logic [13:0] B_ZIN    = 14'h0400;
  localparam logic [13:0] B_ZLOW   = 14'h0200;
  localparam logic [13:0] B_ZHIGH  = 14'h0100;
  localparam logic [13:0] B_PCIN   = 14'h0080;
  localparam logic [13:0] B_READ   = 14'h0040;
  localparam logic [13:0] B_MDRIN  = 14'h0020;
  localparam logic [13:0] B_MDROUT = 14'h0010;
  localparam logic [13:0] B_IRIN   = 14'h0008;
  localparam logic [13:0] B_YIN    = 14'h0004;
  localparam logic [13:0] B_HIIN   = 14'h0002;
  localparam logic [13:0] B_LOIN   = 14'h0001;

  localparam logic [12:0] A_ADD = 13'h1000;
  localparam logic [12:0] A_ROL = 13'h0040;
  localparam logic [12:0] A_MUL = 13'h0008;
  localparam logic [12:0] A_NEG = 13'h0002;

  localparam logic [31:0] IR_ROL = 32'h40918000;  // rol R1,R2,R3
  localparam logic [31:0] IR_MUL = 32'h78130000;  // mul R2,R6
  localparam logic [31:0] IR_NEG = 32'h8A380000;  // neg R4,R7
  localparam logic [31:0] IR_ILL = 32'hF8000000;  // opcode 11111
  localparam logic [31:0] IR_ADD = 32'h18918000;  // add R1,R2,R3

  alu_seq_ctrl dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Rout(Rout), .Rin(Rin), .AluOp(AluOp),
    .Busy(Busy), .Done(Done), .Illegal(Illegal)
  );

  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
                 MDRin, MDRout, IRin, Yin, HIin, LOin};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_cycle(input string tag, input logic [13:0] e_strb,
                              input logic [15:0] e_rout, input logic [15:0] e_rin,
                              input logic [12:0] e_alu, input logic e_busy,
                              input logic e_done, input logic e_ill);
    chk({tag, ".strb"},    32'(strb),    32'(e_strb));
    chk({tag, ".rout"},    32'(Rout),    32'(e_rout));
    chk({tag, ".rin"},     32'(Rin),     32'(e_rin));
    chk({tag, ".aluop"},   32'(AluOp),   32'(e_alu));
    chk({tag, ".busy"},    32'(Busy),    32'(e_busy));
    chk({tag, ".done"},    32'(Done),    32'(e_done));
    chk({tag, ".illegal"}, 32'(Illegal), 32'(e_ill));
  endtask

  task automatic expect_idle(input string tag);
    expect_cycle(tag, 14'h0, 16'h0, 16'h0, 13'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Start edge happens here; returns at cycle 1 (T0)
  task automatic start_instr(input logic [31:0] ir);
    IR    = ir;
    Start = 1'b1;
    tick;
    Start = 1'b0;
  endtask

  // Cycles 1..3; returns at cycle 4 (T3)
  task automatic do_fetch(input string tag);
    expect_cycle({tag, ".T0"}, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".T1"}, B_ZLOW | B_PCIN | B_READ | B_MDRIN, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".T2"}, B_MDROUT | B_IRIN, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
  endtask

  task automatic run_neg(input string tag);
    start_instr(IR_NEG);
    do_fetch(tag);
    expect_cycle({tag, ".T3"}, B_ZIN, 16'h0080, 16'h0, A_NEG, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".T4"}, B_ZLOW, 16'h0, 16'h0010, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".c6"}, 14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_idle({tag, ".idle"});
  endtask

  task automatic run_add(input string tag);
    start_instr(IR_ADD);
    do_fetch(tag);
    expect_cycle({tag, ".T3"}, B_YIN, 16'h0004, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".T4"}, B_ZIN, 16'h0008, 16'h0, A_ADD, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".T5"}, B_ZLOW, 16'h0, 16'h0002, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle({tag, ".c7"}, 14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_idle({tag, ".idle"});
  endtask

  initial begin
    int first_done, second_done, n_done, idle_between;

    Clear = 1'b1;
    Start = 1'b0;
    IR    = 32'h0;
    tick;
    tick;
    expect_idle("reset");
    Clear = 1'b0;
    tick;
    expect_idle("reset.hold");

    // rol R1,R2,R3
    start_instr(IR_ROL);
    do_fetch("rol");
    expect_cycle("rol.T3", B_YIN, 16'h0004, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("rol.T4", B_ZIN, 16'h0008, 16'h0, A_ROL, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("rol.T5", B_ZLOW, 16'h0, 16'h0002, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("rol.c7", 14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_idle("rol.idle");

    // mul R2,R6 with a Start pulse while busy that must be ignored
    start_instr(IR_MUL);
    do_fetch("mul");
    expect_cycle("mul.T3", B_YIN, 16'h0004, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    expect_cycle("mul.T4", B_ZIN, 16'h0040, 16'h0, A_MUL, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("mul.T5", B_ZLOW | B_LOIN, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("mul.T6", B_ZHIGH | B_HIIN, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("mul.c8", 14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b0);
    tick;
    expect_idle("mul.idle");
    tick;
    expect_idle("mul.idle2");

    // neg R4,R7
    run_neg("neg");

    // Illegal opcode, then a legal one must report Illegal=0
    start_instr(IR_ILL);
    do_fetch("ill");
    expect_cycle("ill.T3", 14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b0, 1'b0);
    tick;
    expect_cycle("ill.c5", 14'h0, 16'h0, 16'h0, 13'h0, 1'b1, 1'b1, 1'b1);
    tick;
    expect_idle("ill.idle");
    run_neg("neg2");

    // Clear during T4 of add aborts with no Done
    start_instr(IR_ADD);
    do_fetch("clr");
    tick;
    expect_cycle("clr.T4", B_ZIN, 16'h0008, 16'h0, A_ADD, 1'b1, 1'b0, 1'b0);
    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    expect_idle("clr.c6");
    for (int i = 0; i < 3; i++) begin
      tick;
      expect_idle("clr.after");
    end
    run_add("add");

    // Clear and Start together: Clear wins
    IR    = IR_ROL;
    Start = 1'b1;
    Clear = 1'b1;
    tick;
    Clear = 1'b0;
    Start = 1'b0;
    expect_idle("clr_start");

    // Start held high across two instructions
    first_done   = 0;
    second_done  = 0;
    n_done       = 0;
    idle_between = 0;
    IR    = IR_ROL;
    Start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (Done) begin
        n_done++;
        if (n_done == 1) first_done = c;
        else if (n_done == 2) second_done = c;
      end
      if (!Busy && n_done == 1) idle_between++;
    end
    Start = 1'b0;
    chk("held.done1_cycle", 32'(first_done), 32'd7);
    chk("held.done2_cycle", 32'(second_done), 32'd15);
    chk("held.idle_gap", 32'(idle_between), 32'd1);
    chk("held.done_count", 32'(n_done), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
